// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter that shares one LSB-first bit-serial adder between two requesters.
// Returns the W-bit sum, carry-out and owner ID with a single-cycle done pulse.
module serial_add_arbiter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         owner,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int unsigned CntW = $clog2(W);
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_sr_q, a_sr_d;
  logic [W-1:0]  b_sr_q, b_sr_d;
  logic [W-1:0]  res_q, res_d;
  logic          carry_q, carry_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          win_q, win_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          done_q, done_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          owner_q, owner_d;

  logic s_bit;
  logic c_next;
  logic pick1;

  assign s_bit  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign c_next = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    win_d   = win_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    owner_d = owner_q;
    pick1   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On a tie, favour whichever requester did not win last time.
          pick1   = req1 && (!req0 || !last_q);
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = StAdd;
          if (pick1) begin
            a_sr_d = a1;
            b_sr_d = b1;
            gnt1_d = 1'b1;
            last_d = 1'b1;
            win_d  = 1'b1;
          end else begin
            a_sr_d = a0;
            b_sr_d = b0;
            gnt0_d = 1'b1;
            last_d = 1'b0;
            win_d  = 1'b0;
          end
        end
      end

      StAdd: begin
        carry_d = c_next;
        a_sr_d  = {1'b0, a_sr_q[W-1:1]};
        b_sr_d  = {1'b0, b_sr_q[W-1:1]};
        res_d   = {s_bit, res_q[W-1:1]};
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StDone;
          done_d  = 1'b1;
          sum_d   = {s_bit, res_q[W-1:1]};
          cout_d  = c_next;
          owner_d = win_q;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      win_q   <= win_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      owner_q <= owner_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign owner = owner_q;
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Bench for serial_add_arbiter: schedule-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal results.
module tb_serial_add_arbiter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, busy, done, owner, cout;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  serial_add_arbiter #(.W(W)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .req0 (req0),
    .a0   (a0),
    .b0   (b0),
    .req1 (req1),
    .a1   (a1),
    .b1   (b1),
    .gnt0 (gnt0),
    .gnt1 (gnt1),
    .busy (busy),
    .done (done),
    .owner(owner),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: phase counts cycles since the grant edge (0 = idle).
  // Phase 1 carries the grant, phase W+1 the done pulse; the result is a plain add.
  int           m_phase;
  logic         m_last, m_win, m_owner, m_cout;
  logic [W:0]   m_pend;
  logic [W-1:0] m_sum;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_phase <= 0;
      m_last  <= 1'b1;
      m_win   <= 1'b0;
      m_pend  <= '0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
      m_owner <= 1'b0;
    end else if (m_phase == 0) begin
      if (req0 && (!req1 || m_last)) begin
        m_win   <= 1'b0;
        m_last  <= 1'b0;
        m_pend  <= {1'b0, a0} + {1'b0, b0};
        m_phase <= 1;
      end else if (req1) begin
        m_win   <= 1'b1;
        m_last  <= 1'b1;
        m_pend  <= {1'b0, a1} + {1'b0, b1};
        m_phase <= 1;
      end
    end else if (m_phase == W + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
      if (m_phase == W) begin
        {m_cout, m_sum} <= m_pend;
        m_owner <= m_win;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("gnt0", gnt0, (m_phase == 1) && !m_win);
    chk("gnt1", gnt1, (m_phase == 1) && m_win);
    chk("busy", busy, m_phase != 0);
    chk("done", done, m_phase == W + 1);
    chk("sum", sum, m_sum);
    chk("cout", cout, m_cout);
    chk("owner", owner, m_owner);
  end

  // Issue one request, drop it after the grant, and check the literal result.
  task automatic run_req(input bit which, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] es, input logic ec, input bit mutate,
                         output int gcyc);
    int n;
    bit seen;
    if (which) begin req1 = 1'b1; a1 = a; b1 = b; end
    else begin req0 = 1'b1; a0 = a; b0 = b; end
    seen = 1'b0;
    gcyc = -1;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      if ((which && gnt1) || (!which && gnt0)) begin
        seen = 1'b1;
        gcyc = cyc;
      end
    end
    chk("grant_seen", seen, 1'b1);
    req0 = 1'b0;
    req1 = 1'b0;
    if (mutate) begin a0 = 8'hAA; b0 = 8'h55; end
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
    end
    chk("done_latency", n, W);
    chk("lit_sum", sum, es);
    chk("lit_cout", cout, ec);
    chk("lit_owner", owner, which);
  endtask

  int g, rel;
  int gid[3];
  int gc[3];
  logic [W-1:0] dsum[2];
  logic dcout[2], down[2];
  int k, d;

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {gnt0, gnt1, busy, done, owner, cout, sum}, '0);

    // Single request 0, present from reset release.
    req0 = 1'b1; a0 = 8'h35; b0 = 8'h4A;
    @(negedge clk);
    rst_b = 1'b1;
    rel = cyc;
    run_req(1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, g);
    chk("first_gnt_cycle", g - rel, 1);

    run_req(1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, g);
    run_req(1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b1, g);

    // Results hold while idle.
    repeat (20) @(posedge clk);
    #1;
    chk("hold_sum", sum, 8'h46);
    chk("hold_cout", cout, 1'b0);
    chk("hold_owner", owner, 1'b0);
    chk("hold_idle", {busy, gnt0, gnt1}, 3'b000);

    // Both requesting from reset: alternation and spacing.
    @(negedge clk);
    rst_b = 1'b0;
    req0 = 1'b1; a0 = 8'h80; b0 = 8'h80;
    req1 = 1'b1; a1 = 8'h0F; b1 = 8'h01;
    @(negedge clk);
    rst_b = 1'b1;
    k = 0;
    d = 0;
    for (int i = 0; i < 60 && k < 3; i++) begin
      @(posedge clk); #1;
      if (gnt0 || gnt1) begin gid[k] = gnt1 ? 1 : 0; gc[k] = cyc; k++; end
      if (done && d < 2) begin dsum[d] = sum; dcout[d] = cout; down[d] = owner; d++; end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("rr_grants", k, 3);
    chk("rr_dones", d, 2);
    if (k == 3 && d == 2) begin
      chk("rr_id0", gid[0], 0);
      chk("rr_id1", gid[1], 1);
      chk("rr_id2", gid[2], 0);
      chk("rr_space01", gc[1] - gc[0], W + 2);
      chk("rr_space12", gc[2] - gc[1], W + 2);
      chk("rr_res0", {down[0], dcout[0], dsum[0]}, {1'b0, 1'b1, 8'h00});
      chk("rr_res1", {down[1], dcout[1], dsum[1]}, {1'b1, 1'b0, 8'h10});
    end
    repeat (W + 4) @(posedge clk);
    #1;

    // Reset during the 4th ADD cycle.
    req0 = 1'b1; a0 = 8'h11; b0 = 8'h22;
    k = 0;
    for (int i = 0; i < 30 && k == 0; i++) begin
      @(posedge clk); #1;
      if (gnt0) k = 1;
    end
    chk("mid_gnt", k, 1);
    req0 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_b = 1'b0;
    #1;
    chk("mid_rst_outs", {gnt0, gnt1, busy, done, owner, cout, sum}, '0);
    repeat (2) @(posedge clk);
    req0 = 1'b1; req1 = 1'b1;
    a0 = 8'h01; b0 = 8'h02; a1 = 8'h03; b1 = 8'h04;
    @(negedge clk);
    rst_b = 1'b1;
    k = 0;
    for (int i = 0; i < 10 && k == 0; i++) begin
      @(posedge clk); #1;
      if (gnt0 || gnt1) begin
        k = 1;
        chk("post_rst_winner", {gnt1, gnt0}, 2'b01);
      end
    end
    chk("post_rst_gnt", k, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (W + 4) @(posedge clk);
    #1;
    chk("post_rst_sum", sum, 8'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
